// File: rtl/psum_accum_spad.sv
// Partial-sum scratchpad: accumulates MAC products per entry, then streams all entries out and clears them.
// Optional macro PSUM_SATURATE_EN clamps reduction and accumulation instead of wrapping.
module psum_accum_spad #(
   parameter int PROD_BITWIDTH = 32,
   parameter int PSUM_BITWIDTH = 16,
   parameter int NUM_ENTRIES   = 16,
   parameter int ADDR_BITWIDTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [PROD_BITWIDTH-1:0] prod_in,
   input  logic [ADDR_BITWIDTH-1:0] prod_addr,
   input  logic                     prod_first,
   input  logic                     prod_valid,
   output logic                     prod_ready,
   input  logic                     drain_start,
   output logic [PSUM_BITWIDTH-1:0] psum_out,
   output logic                     psum_out_valid,
   input  logic                     psum_out_ready,
   output logic                     busy
);

   typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_e;

   state_e                   state_q, state_d;
   logic [PSUM_BITWIDTH-1:0] mem_q [NUM_ENTRIES];
   logic [ADDR_BITWIDTH-1:0] drain_ptr_q, drain_ptr_d;

   logic                     prod_acc, drain_acc, drain_last;
   logic [PSUM_BITWIDTH-1:0] base, reduced, sum_d;

   assign prod_ready     = (state_q != DRAIN);
   assign prod_acc       = prod_valid && prod_ready;
   assign psum_out_valid = (state_q == DRAIN);
   assign drain_acc      = psum_out_valid && psum_out_ready;
   assign drain_last     = (drain_ptr_q == ADDR_BITWIDTH'(NUM_ENTRIES - 1));
   assign psum_out       = psum_out_valid ? mem_q[drain_ptr_q] : '0;
   assign busy           = (state_q != IDLE);
   assign base           = prod_first ? '0 : mem_q[prod_addr];

`ifdef PSUM_SATURATE_EN
   logic [PSUM_BITWIDTH:0] wide_sum;
   assign reduced  = (|prod_in[PROD_BITWIDTH-1:PSUM_BITWIDTH]) ? '1 : prod_in[PSUM_BITWIDTH-1:0];
   assign wide_sum = {1'b0, base} + {1'b0, reduced};
   assign sum_d    = wide_sum[PSUM_BITWIDTH] ? '1 : wide_sum[PSUM_BITWIDTH-1:0];
`else
   // Upper product bits are dropped by the modulo-2^PSUM_BITWIDTH reduction.
   logic prod_hi_unused;
   assign prod_hi_unused = ^prod_in[PROD_BITWIDTH-1:PSUM_BITWIDTH];
   assign reduced        = prod_in[PSUM_BITWIDTH-1:0];
   assign sum_d          = base + reduced;
`endif

   always_comb begin
      state_d     = state_q;
      drain_ptr_d = drain_ptr_q;
      case (state_q)
         IDLE: begin
            if (drain_start)   state_d = DRAIN;
            else if (prod_acc) state_d = ACCUM;
         end
         ACCUM: begin
            if (drain_start) state_d = DRAIN;
         end
         DRAIN: begin
            if (drain_acc) begin
               if (drain_last) begin
                  state_d     = IDLE;
                  drain_ptr_d = '0;
               end else begin
                  drain_ptr_d = drain_ptr_q + ADDR_BITWIDTH'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         drain_ptr_q <= '0;
      end else begin
         state_q     <= state_d;
         drain_ptr_q <= drain_ptr_d;
      end
   end

   // Accept and drain beats never coincide: prod_ready is low throughout DRAIN.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_ENTRIES; i++) mem_q[i] <= '0;
      end else if (prod_acc) begin
         mem_q[prod_addr] <= sum_d;
      end else if (drain_acc) begin
         mem_q[drain_ptr_q] <= '0;
      end
   end

endmodule

// File: doc/psum_accum_spad.md
PSUM_ACCUM_SPAD -- requirements
Module: psum_accum_spad

Interface
REQ-001 SHALL have parameter PROD_BITWIDTH, default 32, the width of the MAC product input.
REQ-002 SHALL have parameter PSUM_BITWIDTH, default 16, the stored psum width; it matches the MAC sum_in width.
REQ-003 SHALL have parameter NUM_ENTRIES, default 16, the number of psum scratchpad entries.
REQ-004 SHALL have parameter ADDR_BITWIDTH, default 4, equal to $clog2(NUM_ENTRIES).
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 prod_in  input  PROD_BITWIDTH  unsigned product from the MAC out port.
REQ-008 prod_addr  input  ADDR_BITWIDTH  target entry for prod_in.
REQ-009 prod_first  input  1  when set, the entry is overwritten instead of accumulated into.
REQ-010 prod_valid / prod_ready  input / output  1  product handshake; a transfer occurs when both are high.
REQ-011 drain_start  input  1  single-cycle request to stream out all entries.
REQ-012 psum_out  output  PSUM_BITWIDTH  drained psum value.
REQ-013 psum_out_valid / psum_out_ready  output / input  1  drain handshake.
REQ-014 busy  output  1  high whenever the state is not IDLE.

Function
REQ-015 SHALL implement the FSM states IDLE, ACCUM and DRAIN.
REQ-016 IDLE -> ACCUM on the first accepted product; IDLE or ACCUM -> DRAIN on drain_start; DRAIN -> IDLE after the beat for entry NUM_ENTRIES-1 is accepted.
REQ-017 prod_ready SHALL be 1 in IDLE and ACCUM and 0 in DRAIN.
REQ-018 On an accepted product: entry[prod_addr] <= (prod_first ? 0 : entry[prod_addr]) + reduce(prod_in); the update is visible in the following cycle (1-cycle read-modify-write).
REQ-019 Without the configuration macro, reduce() takes the low PSUM_BITWIDTH bits and the addition wraps modulo 2^PSUM_BITWIDTH.
REQ-020 Back-to-back accepted products to the same address SHALL both accumulate, with no lost update.
REQ-021 If a product is accepted in the same cycle as drain_start:
- the product is committed first;
- DRAIN is entered on the next edge;
- the drained data includes that product.
REQ-022 In DRAIN:
- psum_out_valid=1;
- psum_out = entry[drain_ptr];
- drain_ptr starts at 0 and increments only on psum_out_valid && psum_out_ready.
REQ-023 While psum_out_ready=0, psum_out and drain_ptr SHALL hold stable.
REQ-024 Each drained entry SHALL be cleared to 0 when its beat is accepted, so the scratchpad is all-zero on return to IDLE.
REQ-025 drain_start received in IDLE SHALL drain NUM_ENTRIES zero values.
REQ-026 drain_start asserted during DRAIN SHALL be ignored.
REQ-027 Outside DRAIN: psum_out_valid=0 and psum_out=0.

Reset
REQ-028 While reset=1, asynchronously:
- state=IDLE;
- all entries=0;
- drain_ptr=0;
- prod_ready=1 after release;
- psum_out=0, psum_out_valid=0, busy=0.
REQ-029 Reset asserted mid-ACCUM or mid-DRAIN SHALL abort the operation and discard all stored psums.

Configuration
REQ-030 Macro PSUM_SATURATE_EN: when defined, the following rules SHALL apply:
- if prod_in exceeds 2^PSUM_BITWIDTH-1, reduce() yields all-ones;
- if the accumulation sum exceeds 2^PSUM_BITWIDTH-1, the entry is clamped to 2^PSUM_BITWIDTH-1.
When PSUM_SATURATE_EN is undefined, the wrap behaviour of REQ-019 applies.

Verification
REQ-031 Accumulate: addr 0 gets 61000 with first=1, then 4000 with first=0; then drain -> beat 0 = 65000, beats 1..15 = 0.
REQ-032 Overflow: addr 3 holds 65000, then 25000 (500*50) is added -> drain beat 3 = 24464 without the macro, 65535 with PSUM_SATURATE_EN.
REQ-033 Wide product: prod_in=720000000 (60000*12000) with first=1 at addr 5 -> drain beat 5 = 21504 without the macro, 65535 with it.
REQ-034 Backpressure: psum_out_ready toggles 1,0,0,1 during drain -> every value is held while stalled, 16 beats complete in order, prod_ready stays 0 and busy stays 1 until the last beat.
REQ-035 Simultaneous event and reset: product 8000 accepted at addr 2 in the same cycle as drain_start -> beat 2 = 8000. Then reset is pulsed during beat 4 -> outputs go to 0 immediately, and a subsequent drain returns all zeros.
